sram_controller: RTL and testbench

- Initiator side of the external data-SRAM interface.
- Sits between the ARM memory stage and the 64-bit SRAM model.
- Converts single-word load/store requests into timed SRAM cycles. Holds the pipeline via `ready` for the fixed access time.
- Returns the full 64-bit word pair on reads so a cache can be filled later.

---
 rtl/sram_controller.sv | 94 +++++++++
 tb/tb_sram_controller.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
`timescale 1ns/1ps
`default_nettype none
// sram_controller: turns single-word load/store requests into fixed-length SRAM cycles,
// freezing the pipeline through `ready` and returning the full 64-bit word pair on reads.
module sram_controller #(
  parameter int          WAIT_CYCLES = 5,
  parameter logic [31:0] ADDR_BASE   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [63:0] read_data,
  output logic        ready,
  output logic        SRAM_we_n,
  output logic [16:0] SRAM_addr,
  inout  wire  [63:0] SRAM_dq
);

  localparam int            CW     = $clog2(WAIT_CYCLES) + 1;
  localparam logic [CW-1:0] C_LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_wdata;
  logic [63:0]   r_rdata;
  logic          r_we_n;
  logic [16:0]   r_addr;
  logic [18:0]   w_offset;
  logic          w_unused_bits;
  logic          w_last;

  // Only the low 19 bits of the offset survive the word mapping to 17 address bits.
  assign w_offset      = address[18:0] - ADDR_BASE[18:0];
  assign w_unused_bits = ^{address[31:19], w_offset[1:0]};
  assign w_last        = (r_cnt == C_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (wr_en)      w_next = S_WRITE;
        else if (rd_en) w_next = S_READ;
      end
      S_READ, S_WRITE: begin
        if (w_last) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we_n  <= 1'b1;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_cnt <= '0;
      else if (r_state == S_READ || r_state == S_WRITE)
        r_cnt <= r_cnt + 1'b1;
      // Strobe is asserted on entry to WRITE so it is low for the first WRITE cycle only.
      r_we_n <= ~(r_state == S_IDLE && wr_en);
      if (r_state == S_IDLE && (wr_en || rd_en))
        r_addr <= w_offset[18:2];
      if (r_state == S_IDLE && wr_en)
        r_wdata <= write_data;
      if (r_state == S_READ && w_last)
        r_rdata <= SRAM_dq;
    end
  end

  assign ready     = (r_state == S_IDLE && !rd_en && !wr_en) || (r_state == S_DONE);
  assign read_data = r_rdata;
  assign SRAM_we_n = r_we_n;
  assign SRAM_addr = r_addr;
  assign SRAM_dq   = (r_state == S_WRITE) ? {32'b0, r_wdata} : 64'bz;

endmodule
`default_nettype wire

// File: tb/tb_sram_controller.sv
`timescale 1ns/1ps
`default_nettype none
// tb_sram_controller: scoreboard bench with a behavioural 64-bit SRAM pair model.
module tb_sram_controller;

  localparam int W = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [63:0] read_data;
  logic        ready;
  logic        SRAM_we_n;
  logic [16:0] SRAM_addr;
  wire  [63:0] SRAM_dq;

  logic        sram_oe = 1'b0;
  logic [31:0] mem [0:63];
  logic [5:0]  w_even;
  logic [5:0]  w_odd;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_hold = '0;

  sram_controller #(.WAIT_CYCLES(W), .ADDR_BASE(32'd1024)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .SRAM_we_n  (SRAM_we_n),
    .SRAM_addr  (SRAM_addr),
    .SRAM_dq    (SRAM_dq)
  );

  always #10 clk = ~clk;

  // SRAM model: the pair output is enabled by the bench only during read phases.
  assign w_even  = {SRAM_addr[5:1], 1'b0};
  assign w_odd   = {SRAM_addr[5:1], 1'b1};
  assign SRAM_dq = sram_oe ? {mem[w_odd], mem[w_even]} : 64'bz;

  always @(posedge clk)
    if (SRAM_we_n == 1'b0) mem[SRAM_addr[5:0]] <= SRAM_dq[31:0];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pair(input logic [5:0] w);
    logic [5:0] e;
    logic [5:0] o;
    e = {w[5:1], 1'b0};
    o = {w[5:1], 1'b1};
    return {mem[o], mem[e]};
  endfunction

  // Called on a negedge; with b2b the call happens during DONE and the request is seen next cycle.
  task automatic access(input logic wr, input logic rd, input logic [31:0] addr,
                        input logic [31:0] data, input bit b2b);
    logic [16:0] exp_addr;
    exp_addr   = 17'((addr - 32'd1024) >> 2);
    wr_en      = wr;
    rd_en      = rd;
    address    = addr;
    write_data = data;
    sram_oe    = rd & ~wr;
    if (!wr) exp_hold = pair(exp_addr[5:0]);
    exp_q.push_back(exp_hold);
    #1;
    if (b2b) begin
      check_eq("ready_in_done", {63'b0, ready}, 64'd1);
      @(negedge clk);
    end
    check_eq("ready_req", {63'b0, ready}, 64'd0);
    for (int c = 1; c <= W + 1; c++) begin
      @(negedge clk);
      check_eq("ready", {63'b0, ready}, {63'b0, (c == W + 1)});
      check_eq("we_n", {63'b0, SRAM_we_n}, {63'b0, !(wr && c == 1)});
      check_eq("sram_addr", {47'b0, SRAM_addr}, {47'b0, exp_addr});
      if (wr && c <= W) check_eq("dq_write", SRAM_dq, {32'b0, data});
    end
    check_eq("read_data", read_data, exp_q.pop_front());
  endtask

  task automatic idle(input int n);
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    sram_oe = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check_eq("ready_idle", {63'b0, ready}, 64'd1);
    end
  endtask

  initial begin
    logic [5:0]  rw;
    logic [31:0] rdat;

    repeat (2) @(negedge clk);
    check_eq("rst_we_n", {63'b0, SRAM_we_n}, 64'd1);
    check_eq("rst_addr", {47'b0, SRAM_addr}, 64'd0);
    check_eq("rst_read_data", read_data, 64'd0);
    check_eq("rst_ready", {63'b0, ready}, 64'd1);
    rst = 1'b1;

    access(1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, 1'b0);
    idle(1);
    check_eq("mem2", {32'b0, mem[2]}, 64'hDEADBEEF);
    access(1'b1, 1'b0, 32'd1036, 32'h12345678, 1'b0);
    idle(1);

    access(1'b0, 1'b1, 32'd1036, 32'h0, 1'b0);
    check_eq("read_pair", read_data, 64'h12345678DEADBEEF);
    idle(1);

    access(1'b1, 1'b1, 32'd1024, 32'hA5A5A5A5, 1'b0);
    idle(1);
    check_eq("mem0", {32'b0, mem[0]}, 64'hA5A5A5A5);
    check_eq("rd_held", read_data, 64'h12345678DEADBEEF);

    access(1'b1, 1'b0, 32'd1044, 32'hCAFEF00D, 1'b0);
    idle(1);
    access(1'b1, 1'b0, 32'd1040, 32'h00000011, 1'b0);
    access(1'b0, 1'b1, 32'd1040, 32'h0, 1'b1);
    check_eq("b2b_lo", {32'b0, read_data[31:0]}, 64'h11);
    check_eq("b2b_pair", read_data, 64'hCAFEF00D_00000011);
    idle(1);

    for (int i = 0; i < 4; i++) begin
      rw   = 6'($urandom_range(8, 63));
      rdat = $urandom;
      access(1'b1, 1'b0, 32'd1024 + {24'b0, rw, 2'b00}, rdat, 1'b0);
      idle(1);
      check_eq("rand_mem", {32'b0, mem[rw]}, {32'b0, rdat});
      access(1'b0, 1'b1, 32'd1024 + {24'b0, rw, 2'b00}, 32'h0, 1'b0);
      idle(1);
    end

    access(1'b0, 1'b1, 32'd1036, 32'h0, 1'b0);
    idle(1);
    check_eq("pre_abort", read_data, 64'h12345678DEADBEEF);

    // Reset lands in the third READ cycle.
    rd_en   = 1'b1;
    address = 32'd1036;
    sram_oe = 1'b1;
    #1;
    check_eq("abort_req", {63'b0, ready}, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("abort_read_data", read_data, 64'd0);
    check_eq("abort_we_n", {63'b0, SRAM_we_n}, 64'd1);
    check_eq("abort_addr", {47'b0, SRAM_addr}, 64'd0);
    check_eq("abort_ready_req", {63'b0, ready}, 64'd0);
    rd_en   = 1'b0;
    sram_oe = 1'b0;
    #1;
    check_eq("abort_ready_idle", {63'b0, ready}, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    exp_hold = '0;
    idle(W + 2);
    check_eq("abort_hold", read_data, 64'd0);

    access(1'b0, 1'b1, 32'd1036, 32'h0, 1'b0);
    check_eq("recover_pair", read_data, 64'h12345678DEADBEEF);
    idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
